add_ft_sequencer: RTL and testbench

- Time-redundant, fault-tolerant 16-bit add controller.
- Accepts operand requests over a valid/ready handshake and computes each 16-bit sum by sequencing one shared 4-bit slice adder over four nibble cycles.
- Recomputes the sum with operands swapped, compares the two passes, and retries on mismatch.
- Sits between the operand requester and result consumer as the low-area, fault-detecting alternative to the full-width carry-select datapath.

---
 rtl/add_ft_pkg.sv | 22 ++
 rtl/nibble_slice_adder.sv | 17 +
 rtl/add_ft_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_add_ft_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/add_ft_pkg.sv
// Shared definitions for the time-redundant 16-bit add sequencer.
// Holds the default geometry (operand width, slice width, retry budget), the
// sequencer state encoding and the attempt counter width.
package add_ft_pkg;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_SLICE     = 4;
    localparam int unsigned DEF_NSLICE    = DEF_WIDTH / DEF_SLICE;
    localparam int unsigned DEF_MAX_RETRY = 2;

    // Holds 1..MAX_RETRY+1 for the default retry budget.
    localparam int unsigned ATT_W = 2;

    typedef enum logic [2:0] {
        StIdle,
        StPass1,
        StPass2,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/nibble_slice_adder.sv
// Purely combinational unsigned slice adder: a + b + cin -> SLICE+1 bits.
// Ports:
//   a, b  SLICE-bit operands
//   cin   carry in
//   res   {carry out, SLICE-bit sum}
module nibble_slice_adder #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE:0]   res
);

    assign res = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/add_ft_sequencer.sv
// Fault-tolerant add controller. Each request is summed twice on one shared
// SLICE-bit adder, one slice per cycle: first A+B, then B+A. The two passes are
// compared and the whole computation is retried on mismatch, up to MAX_RETRY
// extra attempts, after which the second-pass result is returned with err set.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    operand request handshake (a, b, c_in)
//   out_valid/out_ready  result handshake (sum, c_out, err, attempts)
//   fault_inj            XORed onto the slice result during the first pass only
module add_ft_sequencer
    import add_ft_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned SLICE     = DEF_SLICE,
    parameter int unsigned MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             err,
    output logic [ATT_W-1:0] attempts,
    input  logic [SLICE:0]   fault_inj
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d;
    logic             c1_q, c1_d, c2_q, c2_d;
    logic [ATT_W-1:0] attempt_q, attempt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             err_q, err_d;
    logic [ATT_W-1:0] attempts_q, attempts_d;

    logic [SLICE-1:0] op_x, op_y;
    logic [SLICE:0]   add_res, slice_res;
    logic             last_slice;

    // Operand mux: the second pass feeds the operands swapped so that a fault
    // tied to one adder input position shows up differently in each pass.
    always_comb begin
        op_x = a_q[int'(idx_q) * SLICE +: SLICE];
        op_y = b_q[int'(idx_q) * SLICE +: SLICE];
        if (state_q == StPass2) begin
            op_x = b_q[int'(idx_q) * SLICE +: SLICE];
            op_y = a_q[int'(idx_q) * SLICE +: SLICE];
        end
    end

    nibble_slice_adder #(
        .SLICE (SLICE)
    ) u_slice_adder (
        .a   (op_x),
        .b   (op_y),
        .cin (carry_q),
        .res (add_res)
    );

    assign slice_res  = add_res ^ ((state_q == StPass1) ? fault_inj : '0);
    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        c1_d       = c1_q;
        c2_d       = c2_q;
        attempt_d  = attempt_q;
        sum_d      = sum_q;
        c_out_d    = c_out_q;
        err_d      = err_q;
        attempts_d = attempts_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    cin_d     = c_in;
                    carry_d   = c_in;
                    idx_d     = '0;
                    attempt_d = ATT_W'(1);
                    state_d   = StPass1;
                end
            end
            StPass1: begin
                r1_d[int'(idx_q) * SLICE +: SLICE] = slice_res[SLICE-1:0];
                carry_d = slice_res[SLICE];
                idx_d   = idx_q + 1'b1;
                if (last_slice) begin
                    c1_d    = slice_res[SLICE];
                    carry_d = cin_q;
                    idx_d   = '0;
                    state_d = StPass2;
                end
            end
            StPass2: begin
                r2_d[int'(idx_q) * SLICE +: SLICE] = slice_res[SLICE-1:0];
                carry_d = slice_res[SLICE];
                idx_d   = idx_q + 1'b1;
                if (last_slice) begin
                    c2_d    = slice_res[SLICE];
                    idx_d   = '0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if ({c1_q, r1_q} == {c2_q, r2_q}) begin
                    sum_d      = r2_q;
                    c_out_d    = c2_q;
                    err_d      = 1'b0;
                    attempts_d = attempt_q;
                    state_d    = StDone;
                end else if (attempt_q <= ATT_W'(MAX_RETRY)) begin
                    attempt_d = attempt_q + 1'b1;
                    carry_d   = cin_q;
                    idx_d     = '0;
                    state_d   = StPass1;
                end else begin
                    // Out of retries: report the operand-swapped pass, which
                    // never sees the injected fault.
                    sum_d      = r2_q;
                    c_out_d    = c2_q;
                    err_d      = 1'b1;
                    attempts_d = attempt_q;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            c1_q       <= 1'b0;
            c2_q       <= 1'b0;
            attempt_q  <= '0;
            sum_q      <= '0;
            c_out_q    <= 1'b0;
            err_q      <= 1'b0;
            attempts_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            c1_q       <= c1_d;
            c2_q       <= c2_d;
            attempt_q  <= attempt_d;
            sum_q      <= sum_d;
            c_out_q    <= c_out_d;
            err_q      <= err_d;
            attempts_q <= attempts_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign err       = err_q;
    assign attempts  = attempts_q;

endmodule

// File: tb/tb_add_ft_sequencer.sv
module tb_add_ft_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        c_out;
    logic        err;
    logic [1:0]  attempts;
    logic [4:0]  fault_inj = '0;

    add_ft_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .err       (err),
        .attempts  (attempts),
        .fault_inj (fault_inj)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        c_out;
        logic        err;
        logic [1:0]  attempts;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    int   val_cyc = 0;
    bit   seen_v  = 1'b0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic e,
                                input logic [1:0] at, input int lat);
        exp_t r;
        r.sum = s; r.c_out = c; r.err = e; r.attempts = at; r.lat = lat;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: timestamps accepts and first out_valid, scores each output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen_v = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (out_valid && !seen_v) begin
                seen_v  = 1'b1;
                val_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                seen_v = 1'b0;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_output: got sum 0x%0h, expected no result", sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", sum, e.sum);
                    chk("c_out", c_out, e.c_out);
                    chk("err", err, e.err);
                    chk("attempts", attempts, e.attempts);
                    chk("latency", val_cyc - acc_cyc, e.lat);
                end
                done_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Call at posedge+2 while idle; fault_inj is cleared fhold cycles after accept.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                         input logic [4:0] finj, input int fhold, input exp_t e);
        exp_q.push_back(e);
        a = ta; b = tb2; c_in = tc; fault_inj = finj; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; c_in = ~tc;
        if (fhold > 0) begin
            repeat (fhold) step();
            fault_inj = '0;
        end
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int k = 0;
        while (done_cnt == start && k < 100) begin
            step();
            k++;
        end
        chk("done_timeout", done_cnt != start, 1);
    endtask

    initial begin
        #12;
        rst = 1'b0;
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_err", err, 0);
        chk("rst_attempts", attempts, 0);

        issue(16'h1234, 16'h4321, 1'b0, 5'd0, 0, mk(16'h5555, 1'b0, 1'b0, 2'd1, 9));
        wait_done();
        issue(16'hFFFF, 16'h0001, 1'b0, 5'd0, 0, mk(16'h0000, 1'b1, 1'b0, 2'd1, 9));
        wait_done();
        issue(16'hFFFF, 16'hFFFF, 1'b1, 5'd0, 0, mk(16'hFFFF, 1'b1, 1'b0, 2'd1, 9));
        wait_done();

        // Transient fault confined to the first PASS1.
        issue(16'h00F0, 16'h0010, 1'b0, 5'b00001, 6, mk(16'h0100, 1'b0, 1'b0, 2'd2, 18));
        wait_done();

        // Hard fault on the carry bit, present on every attempt.
        issue(16'h0000, 16'h0000, 1'b0, 5'b10000, 0, mk(16'h0000, 1'b0, 1'b1, 2'd3, 27));
        wait_done();
        fault_inj = '0;

        // Backpressure: result must hold while a second request is ignored.
        out_ready = 1'b0;
        issue(16'hA5A5, 16'h1111, 1'b0, 5'd0, 0, mk(16'hB6B6, 1'b0, 1'b0, 2'd1, 9));
        begin
            int k = 0;
            while (!out_valid && k < 50) begin
                step();
                k++;
            end
        end
        chk("bp_out_valid", out_valid, 1);
        in_valid = 1'b1; a = 16'h7777; b = 16'h1234; c_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_sum", sum, 16'hB6B6);
            chk("bp_hold_c_out", c_out, 0);
            chk("bp_hold_err", err, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid_held", out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        issue(16'h0F0F, 16'h00F1, 1'b1, 5'd0, 0, mk(16'h1001, 1'b0, 1'b0, 2'd1, 9));
        wait_done();

        // Reset during PASS2 aborts without producing a result.
        a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("pre_rst_in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sum", sum, 0);
        #1;
        rst = 1'b0;
        step();
        issue(16'h0001, 16'h0001, 1'b0, 5'd0, 0, mk(16'h0002, 1'b0, 1'b0, 2'd1, 9));
        wait_done();

        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
